// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and width helpers for the shift-add multiplier
// Contents: mul_state_t (IDLE, RUN, DONE), operand_bits(), count_bits().
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Operand width is the full adder width: groups times bits per group.
    function automatic int operand_bits(input int width, input int height);
        return width * height;
    endfunction

    // Step counter must index 0..n-1; keep at least one bit for tiny n.
    function automatic int count_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_fast_adder2.sv
// rtl/shift_add_multiplier_fast_adder2.sv - two-layer carry-lookahead adder (FastAdder2)
// Ports: a, b (WIDTH*HEIGHT operands), c_in (carry in),
//        sum (WIDTH*HEIGHT result), gg_out / pg_out (whole-word generate / propagate).
module FastAdder2 #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4
) (
    input  logic [WIDTH*HEIGHT-1:0] a,
    input  logic [WIDTH*HEIGHT-1:0] b,
    input  logic                    c_in,
    output logic [WIDTH*HEIGHT-1:0] sum,
    output logic                    gg_out,
    output logic                    pg_out
);

    localparam int N = WIDTH * HEIGHT;

    logic [N-1:0]      bit_g;
    logic [N-1:0]      bit_p;
    logic [HEIGHT-1:0] grp_g;
    logic [HEIGHT-1:0] grp_p;
    logic [HEIGHT:0]   grp_c;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    // First layer: per-group generate / propagate.
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int j = 0; j < HEIGHT; j++) begin
            logic gen;
            logic prop;
            gen  = 1'b0;
            prop = 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                gen  = bit_g[j*WIDTH+i] | (bit_p[j*WIDTH+i] & gen);
                prop = prop & bit_p[j*WIDTH+i];
            end
            grp_g[j] = gen;
            grp_p[j] = prop;
        end
    end

    // Second layer: group carries, then bit carries inside each group.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = c_in;
        for (int j = 0; j < HEIGHT; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < HEIGHT; j++) begin
            logic c;
            c = grp_c[j];
            for (int i = 0; i < WIDTH; i++) begin
                sum[j*WIDTH+i] = bit_p[j*WIDTH+i] ^ c;
                c = bit_g[j*WIDTH+i] | (bit_p[j*WIDTH+i] & c);
            end
        end
    end

    // Whole-word generate ignores c_in; carry out = gg_out | (pg_out & c_in).
    always_comb begin
        gg_out = 1'b0;
        for (int j = 0; j < HEIGHT; j++) begin
            gg_out = grp_g[j] | (grp_p[j] & gg_out);
        end
        pg_out = &grp_p;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
// Ports: clk_in, rst_in (async active-high), start_in, a_in / b_in (N-bit operands),
//        ready_out (idle), done_out (one-cycle completion pulse), product_out (2N-bit result).
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [WIDTH*HEIGHT-1:0]     a_in,
    input  logic [WIDTH*HEIGHT-1:0]     b_in,
    output logic                        ready_out,
    output logic                        done_out,
    output logic [2*WIDTH*HEIGHT-1:0]   product_out
);

    localparam int N  = operand_bits(WIDTH, HEIGHT);
    localparam int CW = count_bits(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic CARRY_IN = 1'b0;

    mul_state_t      state;
    logic [N-1:0]    m_reg;
    logic [N-1:0]    acc;
    logic [N-1:0]    q;
    logic [CW-1:0]   count;

    logic [N-1:0]    addend;
    logic [N-1:0]    sum;
    logic            gg;
    logic            pg;
    logic            cout;
    logic [N-1:0]    acc_next;
    logic [N-1:0]    q_next;

    assign addend = q[0] ? m_reg : '0;

    FastAdder2 #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_adder (
        .a      (acc),
        .b      (addend),
        .c_in   (CARRY_IN),
        .sum    (sum),
        .gg_out (gg),
        .pg_out (pg)
    );

    // With c_in tied low the propagate term drops out; carry out is gg.
    assign cout = gg | (pg & CARRY_IN);

    // {ACC,Q} <= ({cout,sum},Q) >> 1: the N+1-bit sum fits, nothing is lost.
    assign acc_next = {cout, sum[N-1:1]};
    assign q_next   = {sum[0], q[N-1:1]};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            m_reg       <= '0;
            acc         <= '0;
            q           <= '0;
            count       <= '0;
            ready_out   <= 1'b1;
            done_out    <= 1'b0;
            product_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        m_reg     <= a_in;
                        acc       <= '0;
                        q         <= b_in;
                        count     <= '0;
                        ready_out <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        product_out <= {acc_next, q_next};
                        done_out    <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done_out  <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done_out  <= 1'b0;
                    ready_out <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
